program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_checksum.sv | 23 ++
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the framed instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_WR,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   localparam logic [7:0] LD_SYNC_DEFAULT   = 8'hA5;
   localparam int         LD_LEN_ZERO_WORDS = 256;
   // SYNC + LEN + CHK bytes around the payload
   localparam int         LD_FRAME_OVERHEAD = 3;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit wrapping payload sum; o_Pass says whether i_Byte would close the sum to zero.
module loader_checksum (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_Clear,
   input  logic       i_Add,
   input  logic [7:0] i_Byte,
   output logic [7:0] o_Acc,
   output logic       o_Pass
);

   logic [7:0] r_Acc;

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST)       r_Acc <= 8'd0;
      else if (i_Clear) r_Acc <= 8'd0;
      else if (i_Add)   r_Acc <= r_Acc + i_Byte;
   end

   assign o_Acc  = r_Acc;
   assign o_Pass = (8'(r_Acc + i_Byte) == 8'd0);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU while a frame is in flight.
// Define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = LD_SYNC_DEFAULT,
   parameter int         ADDR_W    = 8
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic [7:0]        i_Byte,
   input  logic              i_ByteValid,
   output logic              o_ByteReady,
   output logic              o_WE,
   output logic [ADDR_W-1:0] o_Addr,
   output logic [15:0]       o_WData,
   output logic              o_CPUHold,
   output logic              o_Done,
   output logic              o_Error,
   output logic [ADDR_W:0]   o_WordCount
);

   localparam int CNT_W = ADDR_W + 1;

   ld_state_e         r_State, w_Next;
   logic [ADDR_W-1:0] r_Addr;
   logic [15:0]       r_WData;
   logic [CNT_W-1:0]  r_Len, r_Count;
   logic              r_Hold, r_Done;
   logic              w_Accept, w_Waiting, w_Sync, w_LastWord;
   logic [CNT_W-1:0]  w_CntNext;

   assign w_Accept   = i_ByteValid && o_ByteReady;
   assign w_Waiting  = (r_State == ST_IDLE) || (r_State == ST_DONE) || (r_State == ST_ERR);
   assign w_Sync     = w_Accept && w_Waiting && (i_Byte == SYNC_BYTE);
   assign w_CntNext  = r_Count + CNT_W'(1);
   assign w_LastWord = (w_CntNext >= r_Len);

`ifdef LOADER_CHECKSUM_EN
   logic w_ChkPass;
   logic r_Error;

   loader_checksum u_chk (
      .i_CLK   (i_CLK),
      .i_RST   (i_RST),
      .i_Clear (w_Sync),
      .i_Add   (w_Accept && ((r_State == ST_HI) || (r_State == ST_LO))),
      .i_Byte  (i_Byte),
      .o_Acc   (),
      .o_Pass  (w_ChkPass)
   );

   assign o_Error = r_Error;
`else
   assign o_Error = 1'b0;
`endif

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) r_State <= ST_IDLE;
      else        r_State <= w_Next;
   end

   always_comb begin
      w_Next = r_State;
      unique case (r_State)
         ST_IDLE, ST_DONE, ST_ERR: if (w_Sync)   w_Next = ST_LEN;
         ST_LEN:                   if (w_Accept) w_Next = ST_HI;
         ST_HI:                    if (w_Accept) w_Next = ST_LO;
         ST_LO:                    if (w_Accept) w_Next = ST_WR;
`ifdef LOADER_CHECKSUM_EN
         ST_WR:                    w_Next = w_LastWord ? ST_CHK : ST_HI;
         ST_CHK:                   if (w_Accept) w_Next = w_ChkPass ? ST_DONE : ST_ERR;
`else
         ST_WR:                    w_Next = w_LastWord ? ST_DONE : ST_HI;
         ST_CHK:                   w_Next = ST_IDLE;
`endif
         default:                  w_Next = ST_IDLE;
      endcase
   end

   // WR is the single stall cycle: the write strobe and the only ready-low cycle coincide
   always_comb begin
      o_ByteReady = (r_State != ST_WR);
      o_WE        = (r_State == ST_WR);
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_Addr  <= '0;
         r_WData <= '0;
         r_Len   <= '0;
         r_Count <= '0;
         r_Hold  <= 1'b0;
         r_Done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_Error <= 1'b0;
`endif
      end else begin
         unique case (r_State)
            ST_IDLE, ST_DONE, ST_ERR: if (w_Sync) begin
               r_Done  <= 1'b0;
               r_Count <= '0;
               r_Hold  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
               r_Error <= 1'b0;
`endif
            end
            ST_LEN: if (w_Accept) begin
               r_Len  <= (i_Byte == 8'd0) ? CNT_W'(LD_LEN_ZERO_WORDS) : CNT_W'(i_Byte);
               r_Addr <= '0;
            end
            ST_HI: if (w_Accept) r_WData[15:8] <= i_Byte;
            ST_LO: if (w_Accept) r_WData[7:0]  <= i_Byte;
            ST_WR: begin
               r_Addr  <= r_Addr + ADDR_W'(1);
               r_Count <= w_CntNext;
`ifndef LOADER_CHECKSUM_EN
               if (w_LastWord) begin
                  r_Done <= 1'b1;
                  r_Hold <= 1'b0;
               end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            // a failed frame keeps the CPU held until a good one lands
            ST_CHK: if (w_Accept) begin
               if (w_ChkPass) begin
                  r_Done <= 1'b1;
                  r_Hold <= 1'b0;
               end else begin
                  r_Error <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign o_Addr      = r_Addr;
   assign o_WData     = r_WData;
   assign o_CPUHold   = r_Hold;
   assign o_Done      = r_Done;
   assign o_WordCount = r_Count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, holds, wrap at 256 words, mid-frame reset.
module tb_program_loader;

   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b0;
   logic [7:0]  i_Byte = 8'd0;
   logic        i_ByteValid = 1'b0;
   logic        o_ByteReady, o_WE, o_CPUHold, o_Done, o_Error;
   logic [7:0]  o_Addr;
   logic [15:0] o_WData;
   logic [8:0]  o_WordCount;

   always #5 i_CLK = ~i_CLK;

   program_loader dut (
      .i_CLK       (i_CLK),
      .i_RST       (i_RST),
      .i_Byte      (i_Byte),
      .i_ByteValid (i_ByteValid),
      .o_ByteReady (o_ByteReady),
      .o_WE        (o_WE),
      .o_Addr      (o_Addr),
      .o_WData     (o_WData),
      .o_CPUHold   (o_CPUHold),
      .o_Done      (o_Done),
      .o_Error     (o_Error),
      .o_WordCount (o_WordCount)
   );

   int          checks = 0;
   int          errors = 0;
   int          nwr = 0;
   int          bad_rdy = 0;
   int          gap = 0;
   logic        prev_we = 1'b0;
   logic [15:0] mem [256];
   logic [7:0]  pay [$];

   // write-port model plus ready/strobe relationship watcher
   always @(negedge i_CLK) begin
      if (o_WE) begin
         mem[o_Addr] = o_WData;
         nwr++;
      end
      if (i_RST && (o_ByteReady == o_WE)) bad_rdy++;
      if (o_WE && prev_we) bad_rdy++;
      prev_we = o_WE;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_CLK);
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      i_Byte = b;
      i_ByteValid = 1'b1;
      while (!o_ByteReady && t < 8) begin
         @(negedge i_CLK);
         t++;
      end
      if (!o_ByteReady) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge i_CLK);
      i_ByteValid = 1'b0;
      repeat (gap) @(negedge i_CLK);
   endtask

   task automatic send_frame(input logic [7:0] len, input logic [7:0] ck);
      send(8'hA5);
      send(len);
      foreach (pay[i]) send(pay[i]);
`ifdef LOADER_CHECKSUM_EN
      send(ck);
`else
      if (ck === 8'hxx) idle(0);
`endif
      idle(2);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rdy"},  32'(o_ByteReady), 32'd1);
      chk({tag, "_we"},   32'(o_WE),        32'd0);
      chk({tag, "_addr"}, 32'(o_Addr),      32'd0);
      chk({tag, "_wd"},   32'(o_WData),     32'd0);
      chk({tag, "_hold"}, 32'(o_CPUHold),   32'd0);
      chk({tag, "_done"}, 32'(o_Done),      32'd0);
      chk({tag, "_err"},  32'(o_Error),     32'd0);
      chk({tag, "_wc"},   32'(o_WordCount), 32'd0);
   endtask

   task automatic load_words(input logic [15:0] w0, input logic [15:0] w1);
      pay = {};
      pay.push_back(w0[15:8]); pay.push_back(w0[7:0]);
      pay.push_back(w1[15:8]); pay.push_back(w1[7:0]);
   endtask

   initial begin
      int bad;
      logic [7:0] b8;

      // reset
      idle(3);
      check_reset("rst");
      i_RST = 1'b1;
      idle(2);
      check_reset("post_rst");

      // frame A: A5 02 12 34 AB CD, checksum byte 0x42 closes 0xBE
      foreach (mem[i]) mem[i] = 16'h0;
      nwr = 0;
      send(8'hA5);
      chk("a_hold_rise", 32'(o_CPUHold), 32'd1);
      send(8'h02);
      send(8'h12); send(8'h34);
      send(8'hAB); send(8'hCD);
      chk("a_we_after_lo", 32'(o_WE), 32'd1);
      chk("a_we_addr", 32'(o_Addr), 32'd1);
      chk("a_we_data", 32'(o_WData), 32'hABCD);
      chk("a_rdy_in_wr", 32'(o_ByteReady), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk("a_hold_mid", 32'(o_CPUHold), 32'd1);
      send(8'h42);
`endif
      idle(2);
      chk("a_mem0", 32'(mem[0]), 32'h1234);
      chk("a_mem1", 32'(mem[1]), 32'hABCD);
      chk("a_nwr", 32'(nwr), 32'd2);
      chk("a_done", 32'(o_Done), 32'd1);
      chk("a_err", 32'(o_Error), 32'd0);
      chk("a_hold", 32'(o_CPUHold), 32'd0);
      chk("a_wc", 32'(o_WordCount), 32'd2);
      chk("a_addr", 32'(o_Addr), 32'd2);

`ifdef LOADER_CHECKSUM_EN
      // same frame, wrong checksum
      nwr = 0;
      load_words(16'h1234, 16'hABCD);
      send_frame(8'h02, 8'h43);
      chk("bad_nwr", 32'(nwr), 32'd2);
      chk("bad_err", 32'(o_Error), 32'd1);
      chk("bad_done", 32'(o_Done), 32'd0);
      chk("bad_hold", 32'(o_CPUHold), 32'd1);
`endif

      // leading junk ignored, inner A5 is data; checksum 0x1C closes 0xE4
      foreach (mem[i]) mem[i] = 16'h0;
      nwr = 0;
      send(8'h00);
      send(8'hFF);
      idle(1);
      chk("junk_nwr", 32'(nwr), 32'd0);
      send(8'hA5);
      chk("sync_done_clr", 32'(o_Done), 32'd0);
      chk("sync_wc_clr", 32'(o_WordCount), 32'd0);
      chk("sync_hold", 32'(o_CPUHold), 32'd1);
      send(8'h03);
      send(8'hA5); send(8'h01);
      send(8'h22); send(8'hA5);
      send(8'h33); send(8'h44);
`ifdef LOADER_CHECKSUM_EN
      send(8'h1C);
`endif
      idle(2);
      chk("in_mem0", 32'(mem[0]), 32'hA501);
      chk("in_mem1", 32'(mem[1]), 32'h22A5);
      chk("in_mem2", 32'(mem[2]), 32'h3344);
      chk("in_nwr", 32'(nwr), 32'd3);
      chk("in_wc", 32'(o_WordCount), 32'd3);
      chk("in_done", 32'(o_Done), 32'd1);
      chk("in_err", 32'(o_Error), 32'd0);
      chk("in_hold", 32'(o_CPUHold), 32'd0);

      // frame A again with valid toggling every other cycle
      foreach (mem[i]) mem[i] = 16'h0;
      nwr = 0;
      gap = 1;
      load_words(16'h1234, 16'hABCD);
      send_frame(8'h02, 8'h42);
      gap = 0;
      chk("tog_mem0", 32'(mem[0]), 32'h1234);
      chk("tog_mem1", 32'(mem[1]), 32'hABCD);
      chk("tog_nwr", 32'(nwr), 32'd2);
      chk("tog_done", 32'(o_Done), 32'd1);

      // reset after 3 words of a 5-word frame
      nwr = 0;
      send(8'hA5);
      send(8'h05);
      send(8'h11); send(8'h11);
      send(8'h22); send(8'h22);
      send(8'h33); send(8'h33);
      idle(1);
      chk("mid_nwr", 32'(nwr), 32'd3);
      i_RST = 1'b0;
      #1;
      check_reset("mid_rst");
      idle(2);
      i_RST = 1'b1;
      idle(1);

      // full 5-word frame, checksum 0x02 closes 0xFE
      foreach (mem[i]) mem[i] = 16'h0;
      nwr = 0;
      pay = {};
      for (int w = 1; w <= 5; w++) begin
         b8 = 8'(w * 8'h11);
         pay.push_back(b8);
         pay.push_back(b8);
      end
      send_frame(8'h05, 8'h02);
      chk("five_mem0", 32'(mem[0]), 32'h1111);
      chk("five_mem4", 32'(mem[4]), 32'h5555);
      chk("five_nwr", 32'(nwr), 32'd5);
      chk("five_wc", 32'(o_WordCount), 32'd5);
      chk("five_done", 32'(o_Done), 32'd1);
      chk("five_hold", 32'(o_CPUHold), 32'd0);

      // LEN=0 -> 256 words; each word {i, ~i} sums to 0xFF, 256 of them wrap to 0
      foreach (mem[i]) mem[i] = 16'h0;
      nwr = 0;
      pay = {};
      for (int i = 0; i < 256; i++) begin
         b8 = 8'(i);
         pay.push_back(b8);
         pay.push_back(~b8);
      end
      send_frame(8'h00, 8'h00);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         b8 = 8'(i);
         if (mem[i] !== {b8, ~b8}) bad++;
      end
      chk("full_mem_bad", 32'(bad), 32'd0);
      chk("full_nwr", 32'(nwr), 32'd256);
      chk("full_wc", 32'(o_WordCount), 32'd256);
      chk("full_addr", 32'(o_Addr), 32'd0);
      chk("full_done", 32'(o_Done), 32'd1);
      chk("full_hold", 32'(o_CPUHold), 32'd0);

      chk("ready_vs_we", 32'(bad_rdy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
